// File: rtl/serial_twos_negate_w.sv
// serial_twos_negate_w: LSB-first word-framed serial two's-complement negator with ovf/zero/framing flags
module serial_twos_negate_w #(
    parameter int WIDTH = 8
) (
    input  logic       t_clk,
    input  logic       r,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       sof,
    input  logic [1:0] mode,
    input  logic       neg_en,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_last,
    output logic       ovf,
    output logic       zero,
    output logic       frm_err
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, PASS, INVERT} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt, w_cnt_nx;
    logic          r_neg, w_neg, w_first, w_pass, w_last, w_bit;

    // word state advances only on valid bits; stalls hold everything
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
        end else if (in_valid) begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_neg   <= w_neg;
        end
    end

    // bit 0 comes from IDLE or a sof; before the first 1 bit the output passes, after it inverts when negating
    always_comb begin
        w_first    = (r_state == IDLE) | sof;
        w_cnt      = w_first ? '0 : r_cnt;
        w_neg      = w_first ? ((mode == 2'b01) | ((mode == 2'b10) & neg_en)) : r_neg;
        w_pass     = w_first | (r_state == PASS);
        w_last     = (w_cnt == LAST);
        w_bit      = (w_neg & ~w_pass) ? ~in_bit : in_bit;
        w_cnt_nx   = w_last ? '0 : w_cnt + 1'b1;
        w_state_nx = w_last ? IDLE : ((w_pass & ~in_bit) ? PASS : INVERT);
    end

    // one-cycle registered output stage; a stall clears all outputs
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_bit   <= in_valid & w_bit;
            out_last  <= in_valid & w_last;
            ovf       <= in_valid & w_last & w_neg & w_pass & in_bit;
            zero      <= in_valid & w_last & w_pass & ~in_bit;
            frm_err   <= in_valid & sof & (r_state != IDLE);
        end
    end
endmodule

// File: doc/serial_twos_negate_w.md
Name: serial_twos_negate_w

Overview:
- Bit-serial, word-framed two's-complement negator: parametrised successor of the single-bit serial complementer.
- Takes an LSB-first serial stream of WIDTH-bit words with a valid qualifier and per-word mode (pass / negate / conditional negate).
- Emits the registered result stream with word framing plus overflow, zero and framing-error flags.
- Sits between a serial ADC/shift interface and the serial arithmetic datapath.

Parameters:
- WIDTH, 8, bits per word (2..64); sets the bit-counter width as ceil(log2(WIDTH)).

Ports:
- t_clk  input  1  system clock; all state updates on the rising edge.
- r  input  1  reset: asynchronous, active-high; clears all state.
- in_valid  input  1  in_bit is valid this cycle; low = stall, with no state change except outputs clearing.
- in_bit  input  1  serial data bit, LSB first.
- sof  input  1  start-of-word; qualified by in_valid; forces this bit to be bit 0.
- mode  input  2  00 pass, 01 negate, 10 negate if neg_en, 11 reserved (treated as pass); sampled on bit 0 only.
- neg_en  input  1  conditional-negate enable for mode 10; sampled on bit 0 only.
- out_valid  output  1  out_bit valid (registered).
- out_bit  output  1  result bit, LSB first.
- out_last  output  1  marks the final bit (bit WIDTH-1) of a complete word.
- ovf  output  1  one-cycle pulse with out_last: negation was applied to the most-negative value (1 followed by WIDTH-1 zeros, MSB first).
- zero  output  1  one-cycle pulse with out_last: the result word is all zeros.
- frm_err  output  1  one-cycle pulse: sof arrived while a word was in progress.

Behaviour:
- Reset (r=1, asynchronous):
  - state=IDLE, bit count=0, neg latch=0.
  - All outputs 0.
  - Reset mid-word discards the partial word; no out_last is emitted for it.
- State machine: IDLE, PASS, INVERT.
  - IDLE: next valid bit is bit 0, whether or not sof is present. On that bit, latch neg = (mode==01) | (mode==10 & neg_en).
  - PASS: neg applied but no 1 seen yet. Output bit = input bit. A 1 input moves the machine to INVERT after output.
  - INVERT: output bit = ~input bit when neg=1.
  - When neg=0, the machine still tracks PASS/INVERT (needed for zero), but output always equals the input.
  - Transition out of IDLE, per the bit-0 value: 1 goes to INVERT, 0 goes to PASS.
- Bit counter:
  - Increments per valid bit.
  - On bit WIDTH-1: out_last=1, then state goes to IDLE and the counter goes to 0 (back-to-back words need no gap).
- Latency: exactly 1 cycle from in_valid to out_valid. out_valid=in_valid delayed by one cycle. in_valid=0 gives out_valid=0, with out_last, ovf, zero and frm_err all 0.
- ovf:
  - Evaluated on the last bit.
  - Pulses when neg=1, the state before the last bit was PASS, and in_bit=1.
  - The output for that case is 1 followed by zeros (MSB first), which equals the input (wrap-around, no saturation).
- zero: evaluated on the last bit. Pulses when the pre-last state was PASS and in_bit=0. This holds for any mode.
- sof while PASS/INVERT (mid-word):
  - The partial word is abandoned with no out_last.
  - frm_err pulses with this bit's output.
  - The bit is processed as bit 0 of a new word, with mode and neg_en resampled.
- sof with in_valid=0 is ignored.
- sof in IDLE is legal and gives no error.
- Stall mid-word holds the counter, state and neg latch indefinitely.
- mode/neg_en changes after bit 0 have no effect until the next word.

Test Plan:
- WIDTH=8, mode=01, word 0x06 LSB-first (0,1,1,0,0,0,0,0) back-to-back -> out bits 0,1,0,1,1,1,1,1 (0xFA), out_last on the 8th output, ovf=0, zero=0, each output 1 cycle after its input.
- mode=01, word 0x80 -> out 0x80, ovf=1 and out_last=1 on the same cycle. Then word 0x00 -> out 0x00, zero=1, ovf=0.
- Two words back-to-back: first mode=00, 0xA5, neg_en=x; second mode=10 with neg_en=1, 0x01. No gap -> first out 0xA5, second out 0xFF; out_last pulses on output cycles 8 and 16.
- Word 0x03 with mode=01 and in_valid low for 3 cycles after bit 2 -> out_valid low for exactly those 3 cycles; the result is still 0xFD.
- sof asserted at bit 4 of a word -> frm_err=1 on that bit's output cycle, no out_last for the aborted word. The following 8 bits form a correct word with out_last on the 8th of them.
- r pulsed asynchronously (between clock edges) at bit 5 -> all outputs 0 immediately. The next valid bit is treated as bit 0 and the full word is processed correctly.
